ballot_ctrl: RTL and testbench

BALLOT_CTRL -- requirements
Module: ballot_ctrl

---
 rtl/ballot_ctrl.sv | 154 +++++++++++++++
 tb/tb_ballot_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_ctrl.sv
// ballot_ctrl: three-voter majority ballot controller.
// An IDLE/COLLECT/TALLY/RESULT FSM latches the first vote of each voter and
// publishes majority, unanimity and a wrapping count of completed ballots.
// Optional feature: define BALLOT_TIMEOUT_EN to force a tally after
// TIMEOUT_CYCLES COLLECT cycles; without it COLLECT waits indefinitely.

module ballot_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] vote_vld,
   input  logic [2:0] vote_val,
   input  logic       ack,
   output logic       busy,
   output logic [2:0] voted,
   output logic       result,
   output logic       result_vld,
   output logic       unanimous,
   output logic       timed_out,
   output logic [7:0] ballots
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_TALLY   = 2'd2,
      S_RESULT  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] voted_q, voted_d;
   logic [2:0] votes_q, votes_d;      // latched vote values, 0 for voters not yet heard
   logic       result_q, result_d;
   logic       result_vld_q, result_vld_d;
   logic       unanimous_q, unanimous_d;
   logic [7:0] ballots_q, ballots_d;

`ifdef BALLOT_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt_q, tmo_cnt_d;  // COLLECT cycles already spent in this ballot
   logic       timed_out_q, timed_out_d;
`endif

   // Reject a timeout length the 8-bit counter cannot represent.
   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("ballot_ctrl: TIMEOUT_CYCLES must lie in 2..255");
   end

   // Next-state and next-output logic for the ballot FSM.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
      state_d      = state_q;
      voted_d      = voted_q;
      votes_d      = votes_q;
      result_d     = result_q;
      result_vld_d = result_vld_q;
      unanimous_d  = unanimous_q;
      ballots_d    = ballots_q;
`ifdef BALLOT_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      timed_out_d  = timed_out_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_COLLECT;
               voted_d = 3'b000;
               votes_d = 3'b000;
`ifdef BALLOT_TIMEOUT_EN
               tmo_cnt_d   = 8'd0;
               timed_out_d = 1'b0;
`endif
            end
         end
         S_COLLECT: begin
            // Only voters that have not voted yet may latch; the first vote wins.
            voted_d = voted_q | vote_vld;
            votes_d = votes_q | (vote_vld & ~voted_q & vote_val);
            if (voted_d == 3'b111) begin
               state_d = S_TALLY;
            end
`ifdef BALLOT_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) begin
               state_d     = S_TALLY;
               timed_out_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
`endif
         end
         S_TALLY: begin
            state_d      = S_RESULT;
            result_d     = (votes_q[0] & votes_q[1]) | (votes_q[1] & votes_q[2]) |
                           (votes_q[0] & votes_q[2]);
            unanimous_d  = (voted_q == 3'b111) && (votes_q == 3'b000 || votes_q == 3'b111);
            result_vld_d = 1'b1;
            ballots_d    = ballots_q + 8'd1;
         end
         S_RESULT: begin
            if (ack) begin
               state_d      = S_IDLE;
               result_vld_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset that overrides every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q      <= S_IDLE;
         voted_q      <= 3'b000;
         votes_q      <= 3'b000;
         result_q     <= 1'b0;
         result_vld_q <= 1'b0;
         unanimous_q  <= 1'b0;
         ballots_q    <= 8'd0;
`ifdef BALLOT_TIMEOUT_EN
         tmo_cnt_q    <= 8'd0;
         timed_out_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         voted_q      <= voted_d;
         votes_q      <= votes_d;
         result_q     <= result_d;
         result_vld_q <= result_vld_d;
         unanimous_q  <= unanimous_d;
         ballots_q    <= ballots_d;
`ifdef BALLOT_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         timed_out_q  <= timed_out_d;
`endif
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign voted      = voted_q;
   assign result     = result_q;
   assign result_vld = result_vld_q;
   assign unanimous  = unanimous_q;
   assign ballots    = ballots_q;
`ifdef BALLOT_TIMEOUT_EN
   assign timed_out  = timed_out_q;
`else
   assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_ctrl.sv
// tb_ballot_ctrl: self-checking bench for ballot_ctrl.
// Directed table of ballots, reset and timeout corner cases, randomized
// ballots against a vote-counting model, and the ballot counter wrap.

module tb_ballot_ctrl;

   localparam int TMO = 4;
`ifdef BALLOT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] vote_vld;
   logic [2:0] vote_val;
   logic       ack;
   logic       busy;
   logic [2:0] voted;
   logic       result;
   logic       result_vld;
   logic       unanimous;
   logic       timed_out;
   logic [7:0] ballots;

   int n_pass      = 0;
   int n_total     = 0;
   int exp_ballots = 0;

   ballot_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vote_vld   (vote_vld),
      .vote_val   (vote_val),
      .ack        (ack),
      .busy       (busy),
      .voted      (voted),
      .result     (result),
      .result_vld (result_vld),
      .unanimous  (unanimous),
      .timed_out  (timed_out),
      .ballots    (ballots)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string           name;
      int              ncyc;
      logic [2:0][2:0] vld;
      logic [2:0][2:0] val;
      logic            exp_result;
      logic            exp_unan;
   } vec_t;

   function automatic vec_t mk(input string name, input int ncyc,
                               input logic [2:0] l0, input logic [2:0] v0,
                               input logic [2:0] l1, input logic [2:0] v1,
                               input logic [2:0] l2, input logic [2:0] v2,
                               input logic er, input logic eu);
      vec_t v;
      v.name = name;
      v.ncyc = ncyc;
      v.vld[0] = l0; v.val[0] = v0;
      v.vld[1] = l1; v.val[1] = v1;
      v.vld[2] = l2; v.val[2] = v2;
      v.exp_result = er;
      v.exp_unan   = eu;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"},       int'(busy),       0);
      check({pfx, "_voted"},      int'(voted),      0);
      check({pfx, "_result"},     int'(result),     0);
      check({pfx, "_result_vld"}, int'(result_vld), 0);
      check({pfx, "_unanimous"},  int'(unanimous),  0);
      check({pfx, "_timed_out"},  int'(timed_out),  0);
      check({pfx, "_ballots"},    int'(ballots),    0);
   endtask

   // Accept the result with start held on the same edge, then confirm IDLE
   // keeps the result and voted fields and no new ballot was opened.
   task automatic ack_out(input logic exp_res, input logic [2:0] exp_voted);
      ack = 1'b1;
      start = 1'b1;
      step();
      ack = 1'b0;
      start = 1'b0;
      check("ack_idle", int'(busy), 0);
      check("ack_vld_clr", int'(result_vld), 0);
      check("idle_result_hold", int'(result), int'(exp_res));
      vote_vld = 3'($urandom_range(0, 7));
      vote_val = 3'($urandom_range(0, 7));
      step();
      vote_vld = 3'b000;
      check("no_restart", int'(busy), 0);
      check("idle_voted_hold", int'(voted), int'(exp_voted));
   endtask

   task automatic run_vec(input vec_t v);
      start = 1'b1;
      step();
      start = 1'b0;
      check({v.name, "_busy"}, int'(busy), 1);
      for (int i = 0; i < v.ncyc; i++) begin
         vote_vld = v.vld[i];
         vote_val = v.val[i];
         step();
      end
      vote_vld = 3'b000;
      vote_val = 3'b000;
      check({v.name, "_voted"}, int'(voted), 7);
      check({v.name, "_vld_k1"}, int'(result_vld), 0);
      step();
      exp_ballots++;
      check({v.name, "_vld_k2"}, int'(result_vld), 1);
      check({v.name, "_result"}, int'(result), int'(v.exp_result));
      check({v.name, "_unan"}, int'(unanimous), int'(v.exp_unan));
      check({v.name, "_to"}, int'(timed_out), 0);
      check({v.name, "_ballots"}, int'(ballots), exp_ballots % 256);
      ack_out(v.exp_result, 3'b111);
   endtask

   // Random ballot checked against a model that just records each voter's
   // first vote and counts ones.
   task automatic rand_ballot();
      int         first [3];
      logic [2:0] mask;
      logic [2:0] rv;
      logic [2:0] rl;
      int         c;
      int         ones;
      bit         done;
      bit         exp_to;
      logic       exp_res;
      logic       exp_unan;
      for (int i = 0; i < 3; i++) first[i] = -1;
      mask = 3'b000;
      c = 0;
      done = 1'b0;
      exp_to = 1'b0;
      start = 1'b1;
      step();
      check("rnd_busy", int'(busy), 1);
      while (!done) begin
         c++;
         rv = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) rv = 3'b000;
         if (c > 6) rv = ~mask;
         rl = 3'($urandom_range(0, 7));
         start = 1'($urandom_range(0, 1));
         vote_vld = rv;
         vote_val = rl;
         for (int i = 0; i < 3; i++) begin
            if (rv[i] && first[i] < 0) begin
               first[i] = int'(rl[i]);
               mask[i] = 1'b1;
            end
         end
         step();
         check("rnd_voted", int'(voted), int'(mask));
         if (mask == 3'b111) begin
            done = 1'b1;
         end else if (TO_EN && c == TMO) begin
            done = 1'b1;
            exp_to = 1'b1;
         end
      end
      start = 1'b0;
      vote_vld = 3'b000;
      ones = 0;
      for (int i = 0; i < 3; i++) if (first[i] == 1) ones++;
      exp_res  = (ones >= 2);
      exp_unan = (mask == 3'b111) && (ones == 0 || ones == 3);
      check("rnd_vld_k1", int'(result_vld), 0);
      step();
      exp_ballots++;
      check("rnd_vld_k2", int'(result_vld), 1);
      check("rnd_result", int'(result), int'(exp_res));
      check("rnd_unan", int'(unanimous), int'(exp_unan));
      check("rnd_to", int'(timed_out), int'(exp_to));
      check("rnd_ballots", int'(ballots), exp_ballots % 256);
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
         start = 1'b1;
         vote_vld = 3'($urandom_range(0, 7));
         vote_val = 3'($urandom_range(0, 7));
         step();
         check("hold_vld", int'(result_vld), 1);
         check("hold_result", int'(result), int'(exp_res));
         check("hold_voted", int'(voted), int'(mask));
      end
      vote_vld = 3'b000;
      ack_out(exp_res, mask);
   endtask

   vec_t vecs [5];

   initial begin
      vecs[0] = mk("maj_110",    3, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b000, 1'b1, 1'b0);
      vecs[1] = mk("unan_000",   1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
      vecs[2] = mk("first_wins", 3, 3'b001, 3'b001, 3'b001, 3'b000, 3'b110, 3'b000, 1'b0, 1'b0);
      vecs[3] = mk("split_011",  2, 3'b011, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 1'b1, 1'b0);
      vecs[4] = mk("unan_111",   1, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b1);

      rst = 1'b1;
      start = 1'b0;
      ack = 1'b0;
      vote_vld = 3'b000;
      vote_val = 3'b000;
      step();
      step();
      rst = 1'b0;
      check_zero("reset");

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset mid-ballot with voted=3'b011; a competing vote on the reset edge is overridden.
      start = 1'b1;
      step();
      start = 1'b0;
      vote_vld = 3'b011;
      vote_val = 3'b011;
      step();
      check("mid_voted", int'(voted), 3);
      rst = 1'b1;
      vote_vld = 3'b100;
      step();
      rst = 1'b0;
      vote_vld = 3'b000;
      exp_ballots = 0;
      check_zero("midrst");
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("midrst_ack_busy", int'(busy), 0);
      check("midrst_ack_vld", int'(result_vld), 0);

`ifdef BALLOT_TIMEOUT_EN
      // Only voter2 votes: tally forced on the TMO-th COLLECT cycle.
      start = 1'b1;
      step();
      start = 1'b0;
      vote_vld = 3'b100;
      vote_val = 3'b100;
      step();
      vote_vld = 3'b000;
      step();
      step();
      check("tmo_c3_busy", int'(busy), 1);
      check("tmo_c3_to", int'(timed_out), 0);
      check("tmo_c3_vld", int'(result_vld), 0);
      step();
      check("tmo_c4_to", int'(timed_out), 1);
      check("tmo_c4_vld", int'(result_vld), 0);
      step();
      exp_ballots++;
      check("tmo_vld", int'(result_vld), 1);
      check("tmo_result", int'(result), 0);
      check("tmo_voted", int'(voted), 4);
      check("tmo_unan", int'(unanimous), 0);
      check("tmo_ballots", int'(ballots), exp_ballots % 256);
      ack_out(1'b0, 3'b100);

      // Last vote lands on the timeout edge and completes the ballot.
      start = 1'b1;
      step();
      start = 1'b0;
      vote_vld = 3'b011;
      vote_val = 3'b011;
      step();
      vote_vld = 3'b000;
      step();
      step();
      vote_vld = 3'b100;
      vote_val = 3'b000;
      step();
      vote_vld = 3'b000;
      check("late_voted", int'(voted), 7);
      check("late_to", int'(timed_out), 0);
      step();
      exp_ballots++;
      check("late_vld", int'(result_vld), 1);
      check("late_result", int'(result), 1);
      check("late_to_res", int'(timed_out), 0);
      ack_out(1'b1, 3'b111);
`else
      // No timeout: COLLECT waits as long as votes are missing.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 40; i++) step();
      check("wait_busy", int'(busy), 1);
      check("wait_vld", int'(result_vld), 0);
      check("wait_to", int'(timed_out), 0);
      check("wait_voted", int'(voted), 0);
      vote_vld = 3'b111;
      vote_val = 3'b101;
      step();
      vote_vld = 3'b000;
      check("wait_vld_k1", int'(result_vld), 0);
      step();
      exp_ballots++;
      check("wait_vld_k2", int'(result_vld), 1);
      check("wait_result", int'(result), 1);
      check("wait_unan", int'(unanimous), 0);
      ack_out(1'b1, 3'b111);
`endif

      for (int n = 0; n < 30; n++) rand_ballot();

      while (exp_ballots < 256) run_vec(vecs[4]);
      check("ballots_wrap", int'(ballots), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
